// File: rtl/inst_fifo_pkg.sv
// Shared definitions for the gated PE instruction FIFO: packet type field,
// gating code and the head-state encoding used for coverage.
package inst_fifo_pkg;

    localparam int TYPE_LSB = 0;
    localparam int TYPE_W   = 2;
    localparam logic [TYPE_W-1:0] GATE_CODE = 2'b00;

    typedef enum logic [1:0] {
        HEAD_EMPTY = 2'd0,
        HEAD_PASS  = 2'd1,
        HEAD_WAIT  = 2'd2
    } head_state_e;

    // "New ifmap set" packets must wait for a PE ack before leaving
    function automatic logic is_gated(input logic [TYPE_W-1:0] type_field);
        return (type_field == GATE_CODE);
    endfunction

endpackage

// File: rtl/inst_credit_ctr.sv
// Saturating ack-credit counter: acks bank credits, gated pops spend them,
// an ack arriving at saturation is dropped and reported with a pulse.
module inst_credit_ctr #(
    parameter int CREDIT_MAX = 3,
    localparam int CW = $clog2(CREDIT_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] credits_o,
    output logic          overflow_o
);

    localparam logic [CW-1:0] MAX_C = CW'(CREDIT_MAX);

    logic [CW-1:0] cred_q, cred_d;
    logic          ovf_q, ovf_d;

    // Next-state: flush wins, a simultaneous ack and spend cancel out
    always_comb begin
        cred_d = cred_q;
        ovf_d  = 1'b0;
        if (flush_i) begin
            cred_d = {CW{1'b0}};
        end else begin
            case ({inc_i, dec_i})
                2'b10: begin
                    if (cred_q == MAX_C) begin
                        ovf_d = 1'b1;
                    end else begin
                        cred_d = cred_q + CW'(1);
                    end
                end
                2'b01: begin
                    if (cred_q != {CW{1'b0}}) begin
                        cred_d = cred_q - CW'(1);
                    end else begin
                        cred_d = cred_q;
                    end
                end
                default: cred_d = cred_q;
            endcase
        end
    end

    // Credit and overflow-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cred_q <= {CW{1'b0}};
            ovf_q  <= 1'b0;
        end else begin
            cred_q <= cred_d;
            ovf_q  <= ovf_d;
        end
    end

    assign credits_o  = cred_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/inst_gate_fifo_chk.sv
// Property checker for inst_gate_fifo: pointer/count consistency, bounds
// and output stability under backpressure.
module inst_gate_fifo_chk #(
    parameter int DEPTH      = 16,
    parameter int CREDIT_MAX = 3,
    parameter int DW         = 18,
    localparam int PW   = $clog2(DEPTH) + 1,
    localparam int CNTW = $clog2(DEPTH + 1),
    localparam int CW   = $clog2(CREDIT_MAX + 1)
) (
    input logic            clk,
    input logic            rst_n,
    input logic            flush,
    input logic            pop,
    input logic            empty,
    input logic [PW-1:0]   rp,
    input logic [PW-1:0]   wp,
    input logic [CNTW-1:0] count,
    input logic [CW-1:0]   credits,
    input logic            out_valid,
    input logic            out_ready,
    input logic [DW-1:0]   out_data
);

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);
    a_count_max:    assert property (@(posedge clk) disable iff (!rst_n) count <= CNTW'(DEPTH));
    a_count_ptr:    assert property (@(posedge clk) disable iff (!rst_n) count == CNTW'(wp - rp));
    a_credit_max:   assert property (@(posedge clk) disable iff (!rst_n) credits <= CW'(CREDIT_MAX));
    a_out_stable:   assert property (@(posedge clk) disable iff (!rst_n)
                        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: rtl/inst_gate_fifo.sv
// PE instruction FIFO that holds "new ifmap set" packets at the head until
// an acknowledge credit is available, and tags output with the PE node id.
module inst_gate_fifo
    import inst_fifo_pkg::*;
#(
    parameter int WIDTH      = 14,
    parameter int DEPTH      = 16,
    parameter int NODE_W     = 4,
    parameter int PE_NODE    = 0,
    parameter int CREDIT_MAX = 3,
    parameter int AFULL_TH   = DEPTH - 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1,
    localparam int CNTW = $clog2(DEPTH + 1),
    localparam int CW   = $clog2(CREDIT_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    ack_valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH+NODE_W-1:0] out_data,
    input  logic                    flush,
    output logic [CNTW-1:0]         count,
    output logic                    almost_full,
    output logic [CW-1:0]           credits,
    output logic                    ack_overflow
);

    localparam logic [NODE_W-1:0] NODE_ID = NODE_W'(PE_NODE);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rp_q, rp_d, wp_q, wp_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] head_s;
    logic             empty_s, full_s, gated_head_s;
    logic             push_s, pop_s, gated_pop_s;
    head_state_e      head_state_s;

    assign empty_s      = (rp_q == wp_q);
    assign full_s       = (rp_q[AW] != wp_q[AW]) && (rp_q[AW-1:0] == wp_q[AW-1:0]);
    assign head_s       = mem_q[rp_q[AW-1:0]];
    assign gated_head_s = is_gated(head_s[TYPE_LSB +: TYPE_W]);

    // Head classification; only PASS lets a packet out
    always_comb begin
        head_state_s = HEAD_PASS;
        if (empty_s) begin
            head_state_s = HEAD_EMPTY;
        end else if (gated_head_s && (credits == {CW{1'b0}})) begin
            head_state_s = HEAD_WAIT;
        end else begin
            head_state_s = HEAD_PASS;
        end
    end

    assign out_valid   = (head_state_s == HEAD_PASS);
    assign in_ready    = !full_s;
    assign out_data    = {(empty_s ? {WIDTH{1'b0}} : head_s), NODE_ID};
    assign push_s      = in_valid && !full_s;
    assign pop_s       = out_valid && out_ready;
    assign gated_pop_s = pop_s && gated_head_s;
    assign count       = count_q;
    assign almost_full = (count_q >= CNTW'(AFULL_TH));

    // Pointer and occupancy next-state; flush overrides everything
    always_comb begin
        rp_d    = rp_q;
        wp_d    = wp_q;
        count_d = count_q;
        if (flush) begin
            rp_d    = {PW{1'b0}};
            wp_d    = {PW{1'b0}};
            count_d = {CNTW{1'b0}};
        end else begin
            if (push_s) begin
                wp_d = wp_q + PW'(1);
            end else begin
                wp_d = wp_q;
            end
            if (pop_s) begin
                rp_d = rp_q + PW'(1);
            end else begin
                rp_d = rp_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp_q    <= {PW{1'b0}};
            wp_q    <= {PW{1'b0}};
            count_q <= {CNTW{1'b0}};
        end else begin
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            count_q <= count_d;
        end
    end

    // Packet storage; contents need no reset since empty masks the head
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_q[wp_q[AW-1:0]] <= in_data;
        end
    end

    inst_credit_ctr #(.CREDIT_MAX(CREDIT_MAX)) u_credit (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush),
        .inc_i     (ack_valid),
        .dec_i     (gated_pop_s),
        .credits_o (credits),
        .overflow_o(ack_overflow)
    );

    inst_gate_fifo_chk #(.DEPTH(DEPTH), .CREDIT_MAX(CREDIT_MAX), .DW(WIDTH + NODE_W)) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .pop      (pop_s),
        .empty    (empty_s),
        .rp       (rp_q),
        .wp       (wp_q),
        .count    (count_q),
        .credits  (credits),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

endmodule
